// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, reads one 16-bit word from program
// memory over a req/ack handshake and strobes it into the instruction register.
// A stalled memory is abandoned after TIMEOUT request cycles with an error pulse.
module ifetch #(
    parameter int AW       = 8,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_start,
    input  logic          pc_load,
    input  logic [AW-1:0] pc_load_val,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic          mem_ack,
    input  logic [15:0]   mem_data,
    output logic [15:0]   ir_data,
    output logic          ir_w,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          fetch_done,
    output logic          fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_LOAD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Last wait-counter value before giving up; the counter tracks completed
    // unacknowledged REQ cycles, so reaching TIMEOUT-1 on a non-acked cycle
    // means TIMEOUT REQ cycles have gone by without an ack.
    localparam logic [7:0]    WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [AW-1:0] PC_INIT   = AW'(RESET_PC);
    localparam logic [AW-1:0] PC_STEP   = AW'(1);

    state_t     state_r;
    logic [7:0] wait_cnt_r;

    // Fetch FSM; every output is a flop updated together with the state so
    // nothing reaches an output combinationally from an input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= 8'd0;
            pc         <= PC_INIT;
            mem_addr   <= PC_INIT;
            ir_data    <= 16'h0000;
            mem_rd     <= 1'b0;
            ir_w       <= 1'b0;
            busy       <= 1'b0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    ir_w       <= 1'b0;
                    fetch_done <= 1'b0;
                    fetch_err  <= 1'b0;
                    if (pc_load) begin
                        pc <= pc_load_val;
                    end else begin
                        pc <= pc;
                    end
                    if (fetch_start) begin
                        // A jump in the same cycle fetches from the new target.
                        mem_addr   <= pc_load ? pc_load_val : pc;
                        wait_cnt_r <= 8'd0;
                        mem_rd     <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= S_REQ;
                    end else begin
                        mem_rd     <= 1'b0;
                        busy       <= 1'b0;
                        state_r    <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        // An ack on the final allowed cycle still counts.
                        ir_data    <= mem_data;
                        mem_rd     <= 1'b0;
                        ir_w       <= 1'b1;
                        fetch_done <= 1'b1;
                        state_r    <= S_LOAD;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        mem_rd     <= 1'b0;
                        fetch_err  <= 1'b1;
                        state_r    <= S_ERR;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                        state_r    <= S_REQ;
                    end
                end
                S_LOAD: begin
                    // Post-increment wraps naturally at 2^AW.
                    pc         <= mem_addr + PC_STEP;
                    ir_w       <= 1'b0;
                    fetch_done <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= S_IDLE;
                end
                S_ERR: begin
                    // PC and IR keep their values after an aborted fetch.
                    fetch_err  <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= S_IDLE;
                end
                default: begin
                    mem_rd     <= 1'b0;
                    ir_w       <= 1'b0;
                    fetch_done <= 1'b0;
                    fetch_err  <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit for the 16-bit processor. On request from the control unit it reads one instruction word from program memory at the current PC over a request/acknowledge handshake, then drives the word and a one-cycle write strobe into the instruction register (`ir`: `ir_in`, `w`). It owns the PC: post-increment after each fetch, load for jumps, and a bounded wait with timeout error for memory.

## Interface
- `AW`, 8: program memory address / PC width.
- `RESET_PC`, 0: PC value after reset.
- `TIMEOUT`, 15: max cycles in REQ without `mem_ack` before abort (1..255).

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_start`  in  1  control unit requests one fetch; sampled only in IDLE.
- `pc_load`  in  1  load PC with `pc_load_val`; sampled only in IDLE.
- `pc_load_val`  in  AW  jump target.
- `mem_addr`  out  AW  program memory address.
- `mem_rd`  out  1  memory read request.
- `mem_ack`  in  1  memory data valid this cycle.
- `mem_data`  in  16  instruction word from memory.
- `ir_data`  out  16  word to IR `ir_in`.
- `ir_w`  out  1  IR write strobe (to IR `w`), one cycle.
- `pc`  out  AW  current PC.
- `busy`  out  1  high in any state except IDLE.
- `fetch_done`  out  1  one-cycle pulse, coincident with `ir_w`.
- `fetch_err`  out  1  one-cycle pulse on timeout.

## Operation
- States: IDLE, REQ, LOAD, ERR.
- IDLE: `busy`=0. If `pc_load`: PC <= `pc_load_val`. If `fetch_start`: latch address (= `pc_load_val` when `pc_load` same cycle, else PC) into `mem_addr`, clear wait counter, -> REQ.
- REQ: `mem_rd`=1, `mem_addr` stable. If `mem_ack`: capture `mem_data` into `ir_data`, -> LOAD. Else counter++; when counter reaches `TIMEOUT` without ack -> ERR (ack on that same cycle wins: -> LOAD).
- LOAD: `ir_w`=1, `fetch_done`=1, `ir_data` stable; PC <= `mem_addr`+1 modulo 2^AW (wrap 2^AW-1 -> 0); -> IDLE.
- ERR: `fetch_err`=1 one cycle, `ir_w`=0, PC unchanged, `ir_data` unchanged; -> IDLE.
- `fetch_start`/`pc_load` outside IDLE ignored (not queued); control unit must wait for `busy`=0.
- `mem_ack` outside REQ ignored; `mem_data` sampled only on an acked REQ cycle.
- `ir_data` holds last fetched word between fetches.

## Timing
- Reset values: state IDLE, `pc`=`RESET_PC`, `mem_addr`=`RESET_PC`, `ir_data`=16'h0000, `mem_rd`=0, `ir_w`=0, `busy`=0, `fetch_done`=0, `fetch_err`=0.
- Reset mid-operation (REQ or LOAD): next edge all outputs to reset values; no `ir_w` pulse, PC not incremented.
- Min latency: `fetch_start` high at edge N -> `mem_rd` high cycle N+1; ack in N+1 -> `ir_w` high cycle N+2; IR holds word from edge N+3; `busy` low cycle N+3; next `fetch_start` accepted at edge N+3 (throughput 1 word / 3 cycles at zero wait).
- Each memory wait cycle adds one cycle.
- Timeout: no ack for `TIMEOUT` REQ cycles -> `mem_rd` drops, ERR one cycle, IDLE next.
- All outputs registered; no combinational path input->output.

## Test plan
- Reset then `fetch_start` at PC=0, memory acks in first REQ cycle with 16'h0001 -> `ir_w`=`fetch_done`=1 exactly one cycle with `ir_data`=16'h0001, 2 cycles after start; `pc`=1 after.
- Memory inserts 3 wait cycles, data 16'hA5C3 -> `mem_rd` high 4 cycles, `mem_addr` stable, single `ir_w` with 16'hA5C3.
- `pc_load`=1, `pc_load_val`=8'hFF with `fetch_start` same cycle, data 16'h1234 -> `mem_addr`=8'hFF, `ir_data`=16'h1234, `pc` wraps to 8'h00.
- No `mem_ack` for 15 REQ cycles -> `fetch_err` one-cycle pulse, no `ir_w`, `pc` unchanged, `busy` low following cycle; ack on 15th cycle instead -> normal LOAD, no error.
- `fetch_start` and `pc_load` pulsed while `busy`=1 -> ignored: exactly one fetch, PC unaffected by `pc_load_val`.
- `reset` asserted in REQ (memory stalled) -> next cycle `mem_rd`=0, `pc`=`RESET_PC`, `ir_data`=0, no `ir_w`; late `mem_ack` afterwards ignored.
